// File: rtl/ahb_fb_fill_pkg.sv
// AHB-Lite types shared by the framebuffer fill master.
// Burst, size, transfer and response encodings.
package ahb_fb_fill_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'b000,
    BURST_INCR8  = 3'b101
  } burst_t;

  typedef enum logic [2:0] {
    SIZE_BYTE = 3'b000,
    SIZE_HALF = 3'b001,
    SIZE_WORD = 3'b010
  } size_t;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } trans_t;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } resp_t;

endpackage

// File: rtl/fb_fill_addr_gen.sv
// Pixel walker for the fill master: x/y counters,
// row/beat address and INCR8-vs-SINGLE burst choice.
import ahb_fb_fill_pkg::*;

module fb_fill_addr_gen #(
  parameter addr_t       BASE_ADDR = 32'h0f000000,
  parameter int unsigned STRIDE    = 800,
  parameter int unsigned XW        = 10,
  parameter int unsigned YW        = 9
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic          adv_i,
  input  logic [XW-1:0] x_i,
  input  logic [YW-1:0] y_i,
  input  logic [XW-1:0] w_i,
  input  logic [YW-1:0] h_i,
  output addr_t         addr_o,
  output logic [7:0]    px_o,
  output logic [7:0]    py_o,
  output burst_t        burst_o,
  output logic          first_o,
  output logic          last_o
);

  localparam addr_t ROW_STEP = addr_t'(STRIDE * 4);

  logic [XW-1:0] x0_q, w_q, x_q, col_q;
  logic [YW-1:0] y_q, rows_q;
  addr_t         row_q, addr_q, start_a;
  logic [2:0]    beat_q;
  burst_t        burst_q;
  logic          fits;

  // Start address of the rectangle, and burst choice at each NONSEQ
  always_comb begin
    start_a = BASE_ADDR
            + ((32'(y_i) * STRIDE + 32'(x_i)) << 2);
    fits    = (col_q > XW'(7)) && (addr_q[9:2] <= 8'd248);
    first_o = (beat_q == 3'd0);
    burst_o = first_o ? (fits ? BURST_INCR8 : BURST_SINGLE)
                      : burst_q;
    last_o  = (col_q == XW'(1)) && (rows_q == YW'(1));
  end

  assign addr_o = addr_q;
  assign px_o   = x_q[7:0];
  assign py_o   = y_q[7:0];

  // Step one pixel per accepted address phase; wrap to next row at the edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x0_q    <= '0;
      w_q     <= '0;
      x_q     <= '0;
      col_q   <= '0;
      y_q     <= '0;
      rows_q  <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      beat_q  <= '0;
      burst_q <= BURST_SINGLE;
    end else if (load_i) begin
      x0_q   <= x_i;
      w_q    <= w_i;
      x_q    <= x_i;
      col_q  <= w_i;
      y_q    <= y_i;
      rows_q <= h_i;
      row_q  <= start_a;
      addr_q <= start_a;
      beat_q <= '0;
    end else if (adv_i) begin
      if (col_q == XW'(1)) begin
        row_q  <= row_q + ROW_STEP;
        addr_q <= row_q + ROW_STEP;
        x_q    <= x0_q;
        y_q    <= y_q + YW'(1);
        col_q  <= w_q;
        rows_q <= rows_q - YW'(1);
        beat_q <= '0;
      end else begin
        addr_q  <= addr_q + 32'd4;
        x_q     <= x_q + XW'(1);
        col_q   <= col_q - XW'(1);
        burst_q <= burst_o;
        beat_q  <= (burst_o == BURST_INCR8)
                   ? beat_q + 3'd1 : 3'd0;
      end
    end
  end

endmodule

// File: rtl/ahb_fb_fill.sv
// AHB-Lite write master filling a framebuffer rectangle
// with a solid colour or an x/y coordinate pattern.
import ahb_fb_fill_pkg::*;

module ahb_fb_fill #(
  parameter addr_t       BASE_ADDR = 32'h0f000000,
  parameter int unsigned STRIDE    = 800,
  parameter int unsigned XW        = 10,
  parameter int unsigned YW        = 9
) (
  input  logic          HCLK,
  input  logic          HRESET_N,
  input  logic          START_IN,
  input  logic [XW-1:0] X_IN,
  input  logic [YW-1:0] Y_IN,
  input  logic [XW-1:0] W_IN,
  input  logic [YW-1:0] H_IN,
  input  logic          MODE_IN,
  input  logic [23:0]   COLOUR_IN,
  output logic          BUSY_OUT,
  output logic          DONE_OUT,
  output logic          ERROR_OUT,
  output logic [31:0]   HADDR,
  output logic [2:0]    HBURST,
  output logic [2:0]    HSIZE,
  output logic [1:0]    HTRANS,
  output logic          HWRITE,
  output logic [31:0]   HWDATA,
  input  logic [31:0]   HRDATA,
  input  logic          HREADY,
  input  logic          HRESP
);

  typedef enum logic [1:0] {
    S_IDLE, S_XFER, S_DRAIN, S_ERR
  } state_e;

  state_e        state_q, state_d;
  logic          err_q, err_d;
  logic          dval_q, dval_d;
  data_t         wdata_q, wdata_d;
  logic          mode_q;
  logic [23:0]   colour_q;
  logic          start_ok, zero, accept;
  logic          err_hit, xfer, done;
  addr_t         g_addr;
  logic [7:0]    px, py;
  burst_t        g_burst;
  logic          g_first, g_last;
  data_t         pix;
  logic          unused_rdata;

  assign unused_rdata = ^HRDATA;

  assign start_ok = (state_q == S_IDLE) && START_IN;
  assign zero     = (W_IN == '0) || (H_IN == '0);
  assign xfer     = (state_q == S_XFER);
  assign accept   = xfer && HREADY;
  assign err_hit  = (xfer || state_q == S_DRAIN)
                  && dval_q && HRESP && !HREADY;

  fb_fill_addr_gen #(
    .BASE_ADDR (BASE_ADDR),
    .STRIDE    (STRIDE),
    .XW        (XW),
    .YW        (YW)
  ) u_gen (
    .clk_i   (HCLK),
    .rst_ni  (HRESET_N),
    .load_i  (start_ok),
    .adv_i   (accept),
    .x_i     (X_IN),
    .y_i     (Y_IN),
    .w_i     (W_IN),
    .h_i     (H_IN),
    .addr_o  (g_addr),
    .px_o    (px),
    .py_o    (py),
    .burst_o (g_burst),
    .first_o (g_first),
    .last_o  (g_last)
  );

  // Pixel value for the beat in its address phase
  always_comb begin
    pix = mode_q ? {8'h00, px, py, px ^ py}
                 : {8'h00, colour_q};
  end

  // Next state, data-phase tracking and completion
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    dval_d  = dval_q;
    wdata_d = wdata_q;
    done    = 1'b0;
    if (HREADY) dval_d = accept;
    if (accept) wdata_d = pix;
    unique case (state_q)
      S_IDLE: begin
        if (START_IN) begin
          err_d   = 1'b0;
          state_d = zero ? S_DRAIN : S_XFER;
        end
      end
      S_XFER: begin
        if (err_hit)               state_d = S_ERR;
        else if (accept && g_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (err_hit) begin
          state_d = S_ERR;
        end else if (HREADY || !dval_q) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        if (HREADY) begin
          done    = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and data-phase registers
  always_ff @(posedge HCLK or negedge HRESET_N) begin
    if (!HRESET_N) begin
      state_q  <= S_IDLE;
      err_q    <= 1'b0;
      dval_q   <= 1'b0;
      wdata_q  <= '0;
      mode_q   <= 1'b0;
      colour_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      dval_q  <= dval_d;
      wdata_q <= wdata_d;
      if (start_ok) begin
        mode_q   <= MODE_IN;
        colour_q <= COLOUR_IN;
      end
    end
  end

  assign HADDR     = xfer ? g_addr : '0;
  assign HBURST    = xfer ? g_burst : BURST_SINGLE;
  assign HSIZE     = xfer ? SIZE_WORD : SIZE_BYTE;
  assign HWRITE    = xfer;
  assign HTRANS    = !xfer   ? TRANS_IDLE
                   : g_first ? TRANS_NONSEQ : TRANS_SEQ;
  assign HWDATA    = wdata_q;
  assign BUSY_OUT  = (state_q != S_IDLE);
  assign DONE_OUT  = done;
  assign ERROR_OUT = err_q;

endmodule
